// File: rtl/duck_pkg.sv
// duck_pkg: shared types and constants for the duck spawn controller.
//   duck_state_e : spawn FSM state (IDLE, REQ, FLY, FALL, COOL, DONE)
//   GS_PLAY      : game_state encoding that enables the block
//   SCREEN_W/H, HUD_H, SPRITE_SZ : playfield geometry in pixels
//   clamp10()    : clamps a 10-bit value into [lo, hi]
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    FLY  = 3'd2,
    FALL = 3'd3,
    COOL = 3'd4,
    DONE = 3'd5
  } duck_state_e;

  localparam logic [1:0] GS_PLAY = 2'b01;

  localparam int unsigned SCREEN_W  = 960;
  localparam int unsigned SCREEN_H  = 704;
  localparam int unsigned HUD_H     = 96;
  localparam int unsigned SPRITE_SZ = 64;

  function automatic logic [9:0] clamp10(input logic [9:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/duck_spawn_ctrl_if.sv
// duck_spawn_ctrl_if: request/acknowledge link to the random-position RNG.
//   rng_req : controller -> RNG, a new position is wanted
//   rng_ack : RNG -> controller, one-cycle pulse, position valid
//   rng_hor : RNG -> controller, raw random x
//   rng_ver : RNG -> controller, raw random y
// Handshake: rng_req acts as ready and rng_ack as valid. rng_req stays high
// until the cycle rng_ack is sampled high; rng_hor/rng_ver are taken only on
// that cycle and rng_req is low on the following cycle. rng_ack while rng_req
// is low carries nothing and is ignored.
interface duck_spawn_ctrl_if;
  logic       rng_req;
  logic       rng_ack;
  logic [9:0] rng_hor;
  logic [9:0] rng_ver;

  modport master (output rng_req, input rng_ack, rng_hor, rng_ver);
  modport slave  (input rng_req, output rng_ack, rng_hor, rng_ver);
endinterface

// File: rtl/duck_frame_timer.sv
// duck_frame_timer: loadable frame down-counter.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val (takes priority over tick)
//   load_val  : start count
//   tick      : decrement enable (already qualified by the caller)
//   expire    : high on the tick that brings the count to zero
module duck_frame_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign expire = tick && (count == ONE);

endmodule

// File: rtl/duck_spawn_ctrl.sv
// duck_spawn_ctrl: sequences one duck per spawn slot through request, flight,
// hit/escape and cooldown, and tallies hits and misses for a round.
//   clk, rst       : pixel clock, asynchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame
//   game_state     : game FSM state; only GS_PLAY enables the block
//   rng            : RNG request/acknowledge link (master side)
//   hit            : shot-on-duck pulse
//   duck_x/duck_y  : sprite position
//   duck_visible   : sprite enable; duck_falling selects the falling sprite
//   hit_cnt/miss_cnt : round tallies; round_done : round finished (level)
//   state_dbg      : current FSM state
// Build option: DUCK_SPAWN_CTRL_MOVE_EN enables per-frame movement in FLY and
// FALL; without it the duck stays at its spawn point and FALL ends on the
// first frame_tick.
module duck_spawn_ctrl
  import duck_pkg::*;
#(
  parameter int unsigned DUCK_LIFE_FRAMES = 120,
  parameter int unsigned COOLDOWN_FRAMES  = 30,
  parameter int unsigned DUCKS_PER_ROUND  = 10,
  parameter int unsigned SPEED            = 2,
  parameter int unsigned HOR_MAX          = SCREEN_W - SPRITE_SZ,
  parameter int unsigned VER_MIN          = HUD_H,
  parameter int unsigned VER_MAX          = SCREEN_H - SPRITE_SZ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic [1:0]                game_state,
  duck_spawn_ctrl_if.master         rng,
  input  logic                      hit,
  output logic [9:0]                duck_x,
  output logic [9:0]                duck_y,
  output logic                      duck_visible,
  output logic                      duck_falling,
  output logic [3:0]                hit_cnt,
  output logic [3:0]                miss_cnt,
  output logic                      round_done,
  output duck_state_e               state_dbg
);

`ifdef DUCK_SPAWN_CTRL_MOVE_EN
  localparam bit MOVE_ON = 1'b1;
`else
  localparam bit MOVE_ON = 1'b0;
`endif

  localparam logic [9:0] LIFE_C      = 10'(DUCK_LIFE_FRAMES);
  localparam logic [9:0] COOL_C      = 10'(COOLDOWN_FRAMES);
  localparam logic [4:0] ROUND_C     = 5'(DUCKS_PER_ROUND);
  localparam logic [9:0] SPEED_C     = 10'(SPEED);
  localparam logic [9:0] FALL_STEP_C = 10'(2 * SPEED);
  localparam logic [9:0] HOR_MAX_C   = 10'(HOR_MAX);
  localparam logic [9:0] HOR_HALF_C  = 10'(HOR_MAX / 2);
  localparam logic [9:0] VER_MIN_C   = 10'(VER_MIN);
  localparam logic [9:0] VER_MAX_C   = 10'(VER_MAX);

  duck_state_e state_q, state_d;
  logic       play;
  logic       spawn, clr_cnt, inc_hit, inc_miss, cool_load;
  logic       life_exp, cool_exp, fall_end, round_full;
  logic       fly_step, fall_step;
  logic [9:0] x_q, y_q, spawn_x, spawn_y, x_fly, y_fly, y_fall;
  logic       dir_q, dir_fly;

  assign play       = (game_state == GS_PLAY);
  assign round_full = ({1'b0, hit_cnt} + {1'b0, miss_cnt}) == ROUND_C;
  // Without movement the fall animation is a single frame.
  assign fall_end   = MOVE_ON ? (y_q == VER_MAX_C) : frame_tick;
  assign fly_step   = MOVE_ON && play && frame_tick && (state_q == FLY);
  assign fall_step  = MOVE_ON && play && frame_tick && (state_q == FALL);

  duck_frame_timer #(.W(10)) u_life (
    .clk      (clk),
    .rst      (rst),
    .load     (spawn),
    .load_val (LIFE_C),
    .tick     (frame_tick && (state_q == FLY)),
    .expire   (life_exp)
  );

  duck_frame_timer #(.W(10)) u_cool (
    .clk      (clk),
    .rst      (rst),
    .load     (cool_load),
    .load_val (COOL_C),
    .tick     (frame_tick && (state_q == COOL)),
    .expire   (cool_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Leaving PLAY overrides every state; a hit beats a same-cycle life expiry.
  always_comb begin
    state_d   = state_q;
    spawn     = 1'b0;
    clr_cnt   = 1'b0;
    inc_hit   = 1'b0;
    inc_miss  = 1'b0;
    cool_load = 1'b0;
    if (!play) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          clr_cnt = 1'b1;
          state_d = REQ;
        end
        REQ: if (rng.rng_ack) begin
          spawn   = 1'b1;
          state_d = FLY;
        end
        FLY: begin
          if (hit) begin
            inc_hit = 1'b1;
            state_d = FALL;
          end else if (life_exp) begin
            inc_miss  = 1'b1;
            cool_load = 1'b1;
            state_d   = COOL;
          end
        end
        FALL: if (fall_end) begin
          cool_load = 1'b1;
          state_d   = COOL;
        end
        COOL: if (cool_exp) state_d = round_full ? DONE : REQ;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Spawn clamp and per-frame motion; edge tests precede the add/subtract so
  // the 10-bit values never wrap.
  always_comb begin
    spawn_x = (rng.rng_hor > HOR_MAX_C) ? HOR_HALF_C : rng.rng_hor;
    spawn_y = clamp10(rng.rng_ver, VER_MIN_C, VER_MAX_C);
    x_fly   = x_q;
    dir_fly = dir_q;
    if (dir_q) begin
      if (x_q >= HOR_MAX_C - SPEED_C) begin
        x_fly   = HOR_MAX_C;
        dir_fly = 1'b0;
      end else begin
        x_fly = x_q + SPEED_C;
      end
    end else begin
      if (x_q <= SPEED_C) begin
        x_fly   = '0;
        dir_fly = 1'b1;
      end else begin
        x_fly = x_q - SPEED_C;
      end
    end
    y_fly  = (y_q <= VER_MIN_C + SPEED_C) ? VER_MIN_C : y_q - SPEED_C;
    y_fall = (y_q >= VER_MAX_C - FALL_STEP_C) ? VER_MAX_C : y_q + FALL_STEP_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (clr_cnt) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end
      if (inc_hit)  hit_cnt  <= hit_cnt + 4'd1;
      if (inc_miss) miss_cnt <= miss_cnt + 4'd1;
      if (spawn) begin
        x_q   <= spawn_x;
        y_q   <= spawn_y;
        dir_q <= rng.rng_hor[0];
      end else if (fly_step) begin
        x_q   <= x_fly;
        y_q   <= y_fly;
        dir_q <= dir_fly;
      end else if (fall_step) begin
        y_q <= y_fall;
      end
    end
  end

  assign rng.rng_req  = (state_q == REQ);
  assign duck_visible = (state_q == FLY) || (state_q == FALL);
  assign duck_falling = (state_q == FALL);
  assign round_done   = (state_q == DONE);
  assign duck_x       = x_q;
  assign duck_y       = y_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_duck_spawn_ctrl.sv
// tb_duck_spawn_ctrl: directed bench for duck_spawn_ctrl with a frame-level
// reference model compared on every cycle, plus literal spot checks.
module tb_duck_spawn_ctrl;

  localparam logic [1:0] PLAY_ENC = 2'b01;
  localparam int LIFE = 120, COOLF = 30, DUCKS = 10, SPEED = 2;
  localparam int HOR_MAX = 896, VER_MIN = 96, VER_MAX = 640;
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_FLY = 2, PH_FALL = 3,
                 PH_COOL = 4, PH_DONE = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       frame_tick = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic       hit = 1'b0;
  logic [9:0] duck_x, duck_y;
  logic       duck_visible, duck_falling, round_done;
  logic [3:0] hit_cnt, miss_cnt;
  logic [2:0] state_dbg;

  duck_spawn_ctrl_if rng_if ();

  duck_spawn_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .game_state   (game_state),
    .rng          (rng_if),
    .hit          (hit),
    .duck_x       (duck_x),
    .duck_y       (duck_y),
    .duck_visible (duck_visible),
    .duck_falling (duck_falling),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .round_done   (round_done),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_ph, m_x, m_y, m_dir, m_life, m_cool, m_hits, m_miss;

  task automatic model_reset();
    m_ph = PH_IDLE; m_x = 0; m_y = 0; m_dir = -1;
    m_life = 0; m_cool = 0; m_hits = 0; m_miss = 0;
  endtask

  // Advances the model by one clock using the inputs the DUT will sample.
  task automatic model_step(input bit play, input bit ack, input int hor,
                            input int ver, input bit tk, input bit ht);
    if (!play) begin
      m_ph = PH_IDLE;
      return;
    end
    case (m_ph)
      PH_IDLE: begin
        m_hits = 0; m_miss = 0; m_ph = PH_REQ;
      end
      PH_REQ: if (ack) begin
        m_x = (hor > HOR_MAX) ? HOR_MAX / 2 : hor;
        m_y = ver;
        if (m_y < VER_MIN) m_y = VER_MIN;
        if (m_y > VER_MAX) m_y = VER_MAX;
        m_dir = (hor % 2 == 1) ? 1 : -1;
        m_life = LIFE;
        m_ph = PH_FLY;
      end
      PH_FLY: begin
        if (tk) begin
`ifdef DUCK_SPAWN_CTRL_MOVE_EN
          m_x = m_x + m_dir * SPEED;
          if (m_x <= 0) begin m_x = 0; m_dir = 1; end
          else if (m_x >= HOR_MAX) begin m_x = HOR_MAX; m_dir = -1; end
          m_y = m_y - SPEED;
          if (m_y < VER_MIN) m_y = VER_MIN;
`endif
          m_life = m_life - 1;
        end
        if (ht) begin
          m_hits++; m_ph = PH_FALL;
        end else if (tk && m_life == 0) begin
          m_miss++; m_ph = PH_COOL; m_cool = COOLF;
        end
      end
      PH_FALL: begin
`ifdef DUCK_SPAWN_CTRL_MOVE_EN
        if (m_y == VER_MAX) begin
          m_ph = PH_COOL; m_cool = COOLF;
        end else if (tk) begin
          m_y = m_y + 2 * SPEED;
          if (m_y > VER_MAX) m_y = VER_MAX;
        end
`else
        if (tk) begin m_ph = PH_COOL; m_cool = COOLF; end
`endif
      end
      PH_COOL: if (tk) begin
        m_cool = m_cool - 1;
        if (m_cool == 0) m_ph = (m_hits + m_miss == DUCKS) ? PH_DONE : PH_REQ;
      end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    if (!rst) model_reset();
    check("rng_req",      int'(rng_if.rng_req), int'(m_ph == PH_REQ));
    check("duck_visible", int'(duck_visible),   int'(m_ph == PH_FLY || m_ph == PH_FALL));
    check("duck_falling", int'(duck_falling),   int'(m_ph == PH_FALL));
    check("round_done",   int'(round_done),     int'(m_ph == PH_DONE));
    check("duck_x",       int'(duck_x),         m_x);
    check("duck_y",       int'(duck_y),         m_y);
    check("hit_cnt",      int'(hit_cnt),        m_hits);
    check("miss_cnt",     int'(miss_cnt),       m_miss);
    if (rst) model_step(game_state == PLAY_ENC, rng_if.rng_ack, int'(rng_if.rng_hor),
                        int'(rng_if.rng_ver), frame_tick, hit);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit t, input bit h);
    frame_tick = t;
    hit = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rng_if.rng_req && n < 400) begin
      ticks(1);
      n++;
    end
    check("wait_rng_req", int'(rng_if.rng_req), 1);
  endtask

  task automatic do_ack(input int hor, input int ver);
    repeat (2) step(1'b0, 1'b0);
    rng_if.rng_ack = 1'b1;
    rng_if.rng_hor = 10'(hor);
    rng_if.rng_ver = 10'(ver);
    step(1'b0, 1'b0);
    rng_if.rng_ack = 1'b0;
    rng_if.rng_hor = 10'(hor ^ 10'h2aa);
    rng_if.rng_ver = 10'(ver ^ 10'h155);
  endtask

  int hor_tab[10] = '{17, 250, 899, 512, 3, 777, 1023, 64, 890, 401};
  int ver_tab[10] = '{0, 700, 96, 640, 641, 95, 300, 1023, 500, 150};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rng_if.rng_ack = 1'b0;
    rng_if.rng_hor = '0;
    rng_if.rng_ver = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hit_cnt", int'(hit_cnt), 0);
    check("reset_visible", int'(duck_visible), 0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    game_state = PLAY_ENC;

    // duck 1: out-of-range spawn clamps to (448, 96), then hit
    wait_req();
    do_ack(1000, 20);
    check("spawn_x_clamp", int'(duck_x), 448);
    check("spawn_y_clamp", int'(duck_y), 96);
    check("spawn_visible", int'(duck_visible), 1);
    check("ack_req_low", int'(rng_if.rng_req), 0);
    step(1'b0, 1'b1);
    check("hit1_cnt", int'(hit_cnt), 1);

    // duck 2: escapes after exactly 120 ticks, next request after 30 more
    wait_req();
    do_ack(100, 300);
    ticks(119);
    check("life119_miss", int'(miss_cnt), 0);
    check("life119_vis", int'(duck_visible), 1);
    ticks(1);
    check("life120_miss", int'(miss_cnt), 1);
    check("life120_vis", int'(duck_visible), 0);
    ticks(29);
    check("cool29_req", int'(rng_if.rng_req), 0);
    ticks(1);
    check("cool30_req", int'(rng_if.rng_req), 1);

    // duck 3: hit on the expiring tick wins, then falls to 640
    do_ack(500, 640);
    ticks(119);
    step(1'b1, 1'b1);
    check("tie_hit", int'(hit_cnt), 2);
    check("tie_miss", int'(miss_cnt), 1);
    check("tie_falling", int'(duck_falling), 1);
    n = 0;
    while (duck_visible && n < 200) begin
      ticks(1);
      n++;
    end
    check("fall_vis_drop", int'(duck_visible), 0);
    check("fall_y_end", int'(duck_y), 640);

    // duck 4: right-moving spawn at the edge bounces
    wait_req();
    do_ack(895, 300);
    step(1'b1, 1'b0);
`ifdef DUCK_SPAWN_CTRL_MOVE_EN
    check("bounce_x1", int'(duck_x), 896);
`else
    check("bounce_x1", int'(duck_x), 895);
`endif
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
`ifdef DUCK_SPAWN_CTRL_MOVE_EN
    check("bounce_x2", int'(duck_x), 894);
`else
    check("bounce_x2", int'(duck_x), 895);
`endif
    step(1'b0, 1'b1);
    check("hit4_falling", int'(duck_falling), 1);
    wait_req();
    step(1'b0, 1'b1);
    check("hit_in_req", int'(hit_cnt), 3);

    // duck 5: stray ack in FLY, then leave PLAY mid-flight and re-enter
    do_ack(10, 200);
    ticks(3);
    rng_if.rng_ack = 1'b1;
    rng_if.rng_hor = 10'd5;
    rng_if.rng_ver = 10'd500;
    step(1'b0, 1'b0);
    rng_if.rng_ack = 1'b0;
    game_state = 2'b00;
    step(1'b0, 1'b0);
    check("exit_visible", int'(duck_visible), 0);
    check("exit_req", int'(rng_if.rng_req), 0);
    check("exit_hit_held", int'(hit_cnt), 3);
    check("exit_miss_held", int'(miss_cnt), 1);
    step(1'b0, 1'b1);
    game_state = PLAY_ENC;
    step(1'b0, 1'b0);
    check("reenter_hit_clr", int'(hit_cnt), 0);
    check("reenter_miss_clr", int'(miss_cnt), 0);
    check("reenter_req", int'(rng_if.rng_req), 1);

    // async reset mid-flight
    do_ack(300, 400);
    ticks(2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_vis", int'(duck_visible), 0);
    check("async_rst_x", int'(duck_x), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // full round: alternate hit / miss
    for (int i = 0; i < 10; i++) begin
      wait_req();
      do_ack(hor_tab[i], ver_tab[i]);
      if (i % 2 == 0) begin
        ticks(5);
        step(1'b0, 1'b1);
      end else begin
        ticks(120);
      end
    end
    ticks(30);
    check("round_done", int'(round_done), 1);
    check("round_hits", int'(hit_cnt), 5);
    check("round_miss", int'(miss_cnt), 5);
    check("round_no_req", int'(rng_if.rng_req), 0);
    ticks(5);
    check("done_held", int'(round_done), 1);
    check("done_no_req", int'(rng_if.rng_req), 0);
    game_state = 2'b10;
    step(1'b0, 1'b0);
    check("done_exit", int'(round_done), 0);
    check("done_exit_hits", int'(hit_cnt), 5);
    step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
